kronos_xif_issue_queue: RTL and testbench

- In-order issue/commit buffer between the cv32e40px eXtension-interface issue/commit channels and the Kronos Keccak datapath.
- Claims custom-0 instructions and holds them until the core commits or kills them.
- Dispatches committed instructions one at a time to the datapath.
- Returns each datapath result on the XIF result channel through a registered, back-pressurable slot.

---
 rtl/kronos_xif_issue_queue.sv | 224 ++++++++++++++++++++++
 tb/tb_kronos_xif_issue_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_xif_issue_queue.sv
// In-order issue/commit buffer between the cv32e40px XIF issue/commit channels and the Kronos datapath.
// Claimed custom-0 instructions wait for commit/kill, dispatch one at a time and return through a registered result slot.
module kronos_xif_issue_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned XLEN   = 32,
    parameter logic [6:0]  OPCODE = 7'b0001011
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_instr_i,
    input  logic [XLEN-1:0]          issue_rs0_i,
    input  logic [XLEN-1:0]          issue_rs1_i,
    input  logic [ID_W-1:0]          issue_id_i,
    output logic                     issue_accept_o,
    output logic                     issue_writeback_o,
    input  logic                     commit_valid_i,
    input  logic [ID_W-1:0]          commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     exe_valid_o,
    input  logic                     exe_ready_i,
    output logic [9:0]               exe_funct_o,
    output logic [XLEN-1:0]          exe_rs0_o,
    output logic [XLEN-1:0]          exe_rs1_o,
    output logic [4:0]               exe_rd_o,
    output logic [ID_W-1:0]          exe_id_o,
    input  logic                     dp_done_i,
    input  logic [XLEN-1:0]          dp_data_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [ID_W-1:0]          result_id_o,
    output logic [4:0]               result_rd_o,
    output logic [XLEN-1:0]          result_data_o,
    output logic                     result_we_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        E_EMPTY,
        E_PEND,
        E_CMT,
        E_KILL
    } entry_state_e;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_EXEC,
        DISP_WAIT_RES
    } disp_state_e;

    typedef struct packed {
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs0;
        logic [XLEN-1:0] rs1;
        logic [ID_W-1:0] id;
    } entry_t;

    entry_state_e    state_q [DEPTH];
    entry_state_e    state_d [DEPTH];
    entry_t          entry_q [DEPTH];
    entry_t          entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    disp_state_e     disp_q, disp_d;
    logic [ID_W-1:0] inflight_id_q, inflight_id_d;
    logic [4:0]      inflight_rd_q, inflight_rd_d;
    logic            result_valid_q, result_valid_d;
    logic            result_we_q, result_we_d;
    logic [ID_W-1:0] result_id_q, result_id_d;
    logic [4:0]      result_rd_q, result_rd_d;
    logic [XLEN-1:0] result_data_q, result_data_d;

    logic            push;
    logic            pop;
    logic            exe_valid;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^issue_instr_i[24:15];

    assign issue_accept_o    = (issue_instr_i[6:0] == OPCODE);
    assign issue_writeback_o = (issue_instr_i[6:0] == OPCODE);
    assign issue_ready_o     = (count_q < CNT_W'(DEPTH));

    assign exe_valid_o = exe_valid;
    assign exe_funct_o = {entry_q[head_q].funct7, entry_q[head_q].funct3};
    assign exe_rs0_o   = entry_q[head_q].rs0;
    assign exe_rs1_o   = entry_q[head_q].rs1;
    assign exe_rd_o    = entry_q[head_q].rd;
    assign exe_id_o    = entry_q[head_q].id;

    assign result_valid_o = result_valid_q;
    assign result_we_o    = result_we_q;
    assign result_id_o    = result_id_q;
    assign result_rd_o    = result_rd_q;
    assign result_data_o  = result_data_q;
    assign count_o        = count_q;

    always_comb begin
        state_d        = state_q;
        entry_d        = entry_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        disp_d         = disp_q;
        inflight_id_d  = inflight_id_q;
        inflight_rd_d  = inflight_rd_q;
        result_valid_d = result_valid_q;
        result_we_d    = result_we_q;
        result_id_d    = result_id_q;
        result_rd_d    = result_rd_q;
        result_data_d  = result_data_q;
        exe_valid      = 1'b0;
        pop            = 1'b0;
        push           = issue_valid_i && issue_ready_o && issue_accept_o;

        if (commit_valid_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (state_q[PTR_W'(i)] == E_PEND && entry_q[PTR_W'(i)].id == commit_id_i) begin
                    state_d[PTR_W'(i)] = commit_kill_i ? E_KILL : E_CMT;
                end
            end
        end

        case (disp_q)
            DISP_IDLE: begin
                if (state_q[head_q] == E_CMT) begin
                    exe_valid = 1'b1;
                    if (exe_ready_i) begin
                        pop           = 1'b1;
                        inflight_id_d = entry_q[head_q].id;
                        inflight_rd_d = entry_q[head_q].rd;
                        disp_d        = DISP_EXEC;
                    end
                end else if (state_q[head_q] == E_KILL) begin
                    pop = 1'b1;
                end
            end
            DISP_EXEC: begin
                if (dp_done_i) begin
                    result_valid_d = 1'b1;
                    result_we_d    = 1'b1;
                    result_id_d    = inflight_id_q;
                    result_rd_d    = inflight_rd_q;
                    result_data_d  = dp_data_i;
                    disp_d         = DISP_WAIT_RES;
                end
            end
            DISP_WAIT_RES: begin
                if (result_ready_i) begin
                    result_valid_d = 1'b0;
                    result_we_d    = 1'b0;
                    disp_d         = DISP_IDLE;
                end
            end
            default: disp_d = DISP_IDLE;
        endcase

        if (pop) begin
            state_d[head_q] = E_EMPTY;
            head_d          = head_q + PTR_W'(1);
        end

        // A commit naming the id being issued this cycle lands on the fresh entry.
        if (push) begin
            if (commit_valid_i && commit_id_i == issue_id_i) begin
                state_d[tail_q] = commit_kill_i ? E_KILL : E_CMT;
            end else begin
                state_d[tail_q] = E_PEND;
            end
            entry_d[tail_q].funct7 = issue_instr_i[31:25];
            entry_d[tail_q].funct3 = issue_instr_i[14:12];
            entry_d[tail_q].rd     = issue_instr_i[11:7];
            entry_d[tail_q].rs0    = issue_rs0_i;
            entry_d[tail_q].rs1    = issue_rs1_i;
            entry_d[tail_q].id     = issue_id_i;
            tail_d                 = tail_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[PTR_W'(i)] <= E_EMPTY;
                entry_q[PTR_W'(i)] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            disp_q         <= DISP_IDLE;
            inflight_id_q  <= '0;
            inflight_rd_q  <= '0;
            result_valid_q <= 1'b0;
            result_we_q    <= 1'b0;
            result_id_q    <= '0;
            result_rd_q    <= '0;
            result_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            entry_q        <= entry_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            disp_q         <= disp_d;
            inflight_id_q  <= inflight_id_d;
            inflight_rd_q  <= inflight_rd_d;
            result_valid_q <= result_valid_d;
            result_we_q    <= result_we_d;
            result_id_q    <= result_id_d;
            result_rd_q    <= result_rd_d;
            result_data_q  <= result_data_d;
        end
    end

endmodule

// File: tb/tb_kronos_xif_issue_queue.sv
// Bench for kronos_xif_issue_queue: directed scenarios plus random traffic,
// compared each cycle against a queue-level reference model of the buffer.
module tb_kronos_xif_issue_queue;

    localparam int DEPTH = 4;
    localparam int ST_PEND = 1;
    localparam int ST_CMT  = 2;
    localparam int ST_KILL = 3;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i = '0;
    logic [31:0] issue_rs0_i = '0;
    logic [31:0] issue_rs1_i = '0;
    logic [3:0]  issue_id_i = '0;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i = 1'b0;
    logic [3:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        exe_valid_o;
    logic        exe_ready_i = 1'b0;
    logic [9:0]  exe_funct_o;
    logic [31:0] exe_rs0_o;
    logic [31:0] exe_rs1_o;
    logic [4:0]  exe_rd_o;
    logic [3:0]  exe_id_o;
    logic        dp_done_i = 1'b0;
    logic [31:0] dp_data_i = '0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic [2:0]  count_o;

    kronos_xif_issue_queue dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_rs0_i       (issue_rs0_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_id_i        (issue_id_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .exe_valid_o       (exe_valid_o),
        .exe_ready_i       (exe_ready_i),
        .exe_funct_o       (exe_funct_o),
        .exe_rs0_o         (exe_rs0_o),
        .exe_rs1_o         (exe_rs1_o),
        .exe_rd_o          (exe_rd_o),
        .exe_id_o          (exe_id_o),
        .dp_done_i         (dp_done_i),
        .dp_data_i         (dp_data_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_rd_o       (result_rd_o),
        .result_data_o     (result_data_o),
        .result_we_o       (result_we_o),
        .count_o           (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [9:0]  funct;
        logic [4:0]  rd;
        logic [31:0] rs0;
        logic [31:0] rs1;
        int          st;
    } item_t;

    // Reference: a plain queue of claimed instructions plus the single in-flight op and result slot.
    item_t       mq[$];
    bit          busy;
    bit          resPending;
    logic [3:0]  inflightId;
    logic [4:0]  inflightRd;
    bit          resValid;
    logic [3:0]  resId;
    logic [4:0]  resRd;
    logic [31:0] resData;

    int totalChecks = 0;
    int badChecks = 0;
    int obsDispatches = 0;
    int obsResults = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clearModel();
        mq.delete();
        busy = 0;
        resPending = 0;
        resValid = 0;
        inflightId = '0;
        inflightRd = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_ni = 1'b0;
        issue_valid_i = 1'b0;
        commit_valid_i = 1'b0;
        exe_ready_i = 1'b0;
        dp_done_i = 1'b0;
        result_ready_i = 1'b0;
        #1;
        checkOutput("rst_count", 64'(count_o), 64'd0);
        checkOutput("rst_exe_valid", 64'(exe_valid_o), 64'd0);
        checkOutput("rst_result_valid", 64'(result_valid_o), 64'd0);
        checkOutput("rst_result_we", 64'(result_we_o), 64'd0);
        checkOutput("rst_result_data", 64'(result_data_o), 64'd0);
        checkOutput("rst_result_id", 64'(result_id_o), 64'd0);
        clearModel();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic [31:0] rs0,
                                 input logic [31:0] rs1, input logic [3:0] id, input logic cv,
                                 input logic [3:0] cid, input logic kill, input logic er,
                                 input logic done, input logic [31:0] data, input logic rr);
        item_t it;
        bit acc, push, expExe, popDisp, popKill;
        @(negedge clk);
        issue_valid_i = iv;
        issue_instr_i = instr;
        issue_rs0_i = rs0;
        issue_rs1_i = rs1;
        issue_id_i = id;
        commit_valid_i = cv;
        commit_id_i = cid;
        commit_kill_i = kill;
        exe_ready_i = er;
        dp_done_i = done;
        dp_data_i = data;
        result_ready_i = rr;
        #1;
        acc = (instr[6:0] == 7'b0001011);
        expExe = !busy && mq.size() > 0 && mq[0].st == ST_CMT;
        checkOutput("issue_ready", 64'(issue_ready_o), 64'(mq.size() < DEPTH));
        checkOutput("issue_accept", 64'(issue_accept_o), 64'(acc));
        checkOutput("issue_writeback", 64'(issue_writeback_o), 64'(acc));
        checkOutput("count", 64'(count_o), 64'(mq.size()));
        checkOutput("exe_valid", 64'(exe_valid_o), 64'(expExe));
        if (expExe) begin
            checkOutput("exe_funct", 64'(exe_funct_o), 64'(mq[0].funct));
            checkOutput("exe_rs0", 64'(exe_rs0_o), 64'(mq[0].rs0));
            checkOutput("exe_rs1", 64'(exe_rs1_o), 64'(mq[0].rs1));
            checkOutput("exe_rd", 64'(exe_rd_o), 64'(mq[0].rd));
            checkOutput("exe_id", 64'(exe_id_o), 64'(mq[0].id));
        end
        checkOutput("result_valid", 64'(result_valid_o), 64'(resValid));
        if (resValid) begin
            checkOutput("result_id", 64'(result_id_o), 64'(resId));
            checkOutput("result_rd", 64'(result_rd_o), 64'(resRd));
            checkOutput("result_data", 64'(result_data_o), 64'(resData));
            checkOutput("result_we", 64'(result_we_o), 64'd1);
        end
        if (exe_valid_o && er) obsDispatches++;
        if (result_valid_o && rr) obsResults++;

        push = iv && mq.size() < DEPTH && acc;
        popDisp = expExe && er;
        popKill = !busy && mq.size() > 0 && mq[0].st == ST_KILL;
        if (resValid) begin
            if (rr) begin
                resValid = 0;
                busy = 0;
            end
        end else if (busy) begin
            if (done) begin
                resValid = 1;
                resId = inflightId;
                resRd = inflightRd;
                resData = data;
            end
        end else if (popDisp) begin
            busy = 1;
            inflightId = mq[0].id;
            inflightRd = mq[0].rd;
        end
        if (cv) begin
            foreach (mq[i]) begin
                if (mq[i].st == ST_PEND && mq[i].id == cid) mq[i].st = kill ? ST_KILL : ST_CMT;
            end
        end
        if (popDisp || popKill) void'(mq.pop_front());
        if (push) begin
            it.id = id;
            it.funct = {instr[31:25], instr[14:12]};
            it.rd = instr[11:7];
            it.rs0 = rs0;
            it.rs1 = rs1;
            it.st = (cv && cid == id) ? (kill ? ST_KILL : ST_CMT) : ST_PEND;
            mq.push_back(it);
        end
    endtask

    task automatic idleCycles(input int n, input logic er, input logic done, input logic [31:0] data,
                              input logic rr);
        for (int k = 0; k < n; k++) begin
            applyStimulus(0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 4'h0, 0, er, done, data, rr);
        end
    endtask

    task automatic issueOp(input logic [31:0] instr, input logic [31:0] rs0, input logic [3:0] id);
        applyStimulus(1, instr, rs0, ~rs0, id, 0, 4'h0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic commitOp(input logic [3:0] id, input logic kill, input logic er);
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 4'h0, 1, id, kill, er, 0, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] heldData;
        logic [31:0] instr;
        logic [3:0]  cid;
        int          pendIdx[$];

        clearModel();
        doReset();

        // Single op through the whole path.
        issueOp(32'h0000_200B, 32'd5, 4'd3);
        commitOp(4'd3, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 4'h0, 0, 1, 0, 32'h0, 0);
        checkOutput("single_funct", 64'(exe_funct_o), 64'h002);
        checkOutput("single_rs0", 64'(exe_rs0_o), 64'd5);
        idleCycles(3, 0, 0, 32'h0, 0);
        idleCycles(1, 0, 1, 32'hDEAD_BEEF, 0);
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 0, 32'h0, 1);
        checkOutput("single_res_id", 64'(result_id_o), 64'd3);
        checkOutput("single_res_data", 64'(result_data_o), 64'hDEAD_BEEF);
        checkOutput("single_res_we", 64'(result_we_o), 64'd1);
        idleCycles(1, 0, 0, 32'h0, 0);
        checkOutput("single_count_end", 64'(count_o), 64'd0);

        // Non-Kronos instruction completes the handshake unclaimed.
        applyStimulus(1, 32'h0000_0033, 32'h1, 32'h2, 4'd6, 0, 4'h0, 0, 1, 0, 32'h0, 0);
        checkOutput("nonk_ready", 64'(issue_ready_o), 64'd1);
        checkOutput("nonk_accept", 64'(issue_accept_o), 64'd0);
        idleCycles(2, 1, 0, 32'h0, 0);
        checkOutput("nonk_count", 64'(count_o), 64'd0);

        // Fill to full; the fifth offer is refused.
        for (int k = 0; k < 5; k++) issueOp(32'h0010_300B | (k << 7), 32'(k), 4'(k));
        checkOutput("full_ready", 64'(issue_ready_o), 64'd0);
        checkOutput("full_count", 64'(count_o), 64'd4);
        commitOp(4'd0, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 4'h0, 0, 1, 0, 32'h0, 0);
        idleCycles(1, 0, 0, 32'h0, 0);
        checkOutput("full_ready_after_pop", 64'(issue_ready_o), 64'd1);
        idleCycles(1, 0, 1, 32'h1234_5678, 0);
        idleCycles(2, 0, 0, 32'h0, 1);
        doReset();

        // Kill the middle of three.
        obsDispatches = 0;
        obsResults = 0;
        for (int k = 1; k <= 3; k++) issueOp(32'h0000_100B, 32'(k * 16), 4'(k));
        commitOp(4'd2, 1, 0);
        commitOp(4'd1, 0, 0);
        commitOp(4'd3, 0, 0);
        idleCycles(20, 1, 1, 32'hCAFE_0000, 1);
        checkOutput("kill_dispatches", 64'(obsDispatches), 64'd2);
        checkOutput("kill_results", 64'(obsResults), 64'd2);
        checkOutput("kill_count", 64'(count_o), 64'd0);

        // A pending head blocks a younger committed op; result held under back-pressure.
        issueOp(32'h0000_400B, 32'hAA, 4'd4);
        issueOp(32'h0000_500B, 32'hBB, 4'd5);
        commitOp(4'd5, 0, 1);
        for (int k = 0; k < 3; k++) begin
            idleCycles(1, 1, 0, 32'h0, 0);
            checkOutput("order_blocked", 64'(exe_valid_o), 64'd0);
        end
        commitOp(4'd4, 0, 1);
        idleCycles(1, 1, 0, 32'h0, 0);
        idleCycles(1, 0, 1, 32'h4444_4444, 0);
        idleCycles(1, 1, 0, 32'h0, 0);
        heldData = result_data_o;
        checkOutput("bp_first_data", 64'(heldData), 64'h4444_4444);
        for (int k = 0; k < 5; k++) begin
            idleCycles(1, 1, 1, 32'h9999_9999, 0);
            checkOutput("bp_stable_data", 64'(result_data_o), 64'(heldData));
            checkOutput("bp_no_dispatch", 64'(exe_valid_o), 64'd0);
        end
        idleCycles(1, 1, 0, 32'h0, 1);
        idleCycles(6, 1, 1, 32'h5555_5555, 1);
        checkOutput("order_count", 64'(count_o), 64'd0);

        // Same-cycle issue+commit, then reset while the op executes.
        applyStimulus(1, 32'h0000_700B, 32'h77, 32'h78, 4'd7, 1, 4'd7, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 4'h0, 0, 1, 0, 32'h0, 0);
        checkOutput("sc_exe_valid", 64'(exe_valid_o), 64'd1);
        checkOutput("sc_exe_id", 64'(exe_id_o), 64'd7);
        idleCycles(1, 0, 0, 32'h0, 0);
        doReset();
        idleCycles(5, 1, 1, 32'hBAD0_0000, 1);
        checkOutput("post_rst_count", 64'(count_o), 64'd0);
        checkOutput("post_rst_result_valid", 64'(result_valid_o), 64'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                instr = $urandom;
                instr[6:0] = ($urandom_range(0, 9) < 7) ? 7'b0001011 : 7'($urandom);
                pendIdx = mq.find_index with (item.st == ST_PEND);
                if (pendIdx.size() > 0 && $urandom_range(0, 9) < 7)
                    cid = mq[pendIdx[$urandom_range(0, pendIdx.size() - 1)]].id;
                else
                    cid = 4'($urandom_range(0, 7));
                applyStimulus($urandom_range(0, 1) == 1, instr, $urandom, $urandom,
                              4'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, cid,
                              $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
                              $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 1) == 1);
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
